text_term_writer: RTL and testbench

Writer side of the text-mode display path. Accepts ASCII key codes over a valid/ready handshake and writes character codes into the character RAM's write port. Maintains the cursor position and exports it to the VGA text renderer, which highlights the cell whose address equals `cur`. After reset, or on ESC, it clears the screen to spaces.

---
 rtl/text_term_writer.sv | 187 ++++++++++++++++++
 tb/tb_text_term_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_term_writer.sv
// rtl/text_term_writer.sv - keyboard-to-character-RAM writer with cursor tracking and screen clear
module text_term_writer #(
   parameter int COLS   = 71,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_valid,
   input  logic [7:0]        key_ascii,
   output logic              key_ready,
   output logic              we,
   output logic [ADDR_W-1:0] count,
   output logic [7:0]        ascdata,
   output logic [ADDR_W-1:0] cur
);

   localparam int CELLS = COLS * ROWS;
   localparam int COL_W = $clog2(COLS + 1);
   localparam int ROW_W = $clog2(ROWS + 1);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CH_ENTER = 8'h0D;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_ESC   = 8'h1B;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  clr_q, clr_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ADDR_W-1:0]  cur_q, cur_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  count_q, count_d;
   logic [7:0]         ascdata_q, ascdata_d;
   logic               key_ready_q, key_ready_d;

   logic               accept;
   logic               is_print;

   assign accept   = key_valid && key_ready_q && (state_q == ST_IDLE);
   assign is_print = (key_ascii >= CH_SPACE) && (key_ascii <= CH_TILDE);

   // Next-state, cursor and write-port decode; every output is registered
   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      row_d       = row_q;
      col_d       = col_q;
      cur_d       = cur_q;
      we_d        = 1'b0;
      count_d     = count_q;
      ascdata_d   = ascdata_q;
      key_ready_d = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            we_d      = 1'b1;
            count_d   = clr_q;
            ascdata_d = CH_SPACE;
            if (clr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               clr_d   = '0;
            end else begin
               clr_d = clr_q + ADDR_W'(1);
            end
         end

         ST_IDLE: begin
            key_ready_d = 1'b1;
            if (accept) begin
               if (is_print) begin
                  // Write at the current cell, then step right with row/screen wrap
                  we_d        = 1'b1;
                  count_d     = cur_q;
                  ascdata_d   = key_ascii;
                  key_ready_d = 1'b0;
                  state_d     = ST_WRITE;
                  if (col_q == LAST_COL) begin
                     col_d = '0;
                     if (row_q == LAST_ROW) begin
                        row_d = '0;
                        cur_d = '0;
                     end else begin
                        row_d = row_q + ROW_W'(1);
                        cur_d = cur_q + ADDR_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                     cur_d = cur_q + ADDR_W'(1);
                  end
               end else if (key_ascii == CH_ENTER) begin
                  // Start of next row: drop the column, add one row width
                  col_d = '0;
                  if (row_q == LAST_ROW) begin
                     row_d = '0;
                     cur_d = '0;
                  end else begin
                     row_d = row_q + ROW_W'(1);
                     cur_d = cur_q - ADDR_W'(col_q) + COLS_A;
                  end
               end else if (key_ascii == CH_BS) begin
                  // Step back one cell and blank it; nothing to do at the home cell
                  if (cur_q != '0) begin
                     we_d        = 1'b1;
                     count_d     = cur_q - ADDR_W'(1);
                     ascdata_d   = CH_SPACE;
                     key_ready_d = 1'b0;
                     state_d     = ST_WRITE;
                     cur_d       = cur_q - ADDR_W'(1);
                     if (col_q == '0) begin
                        col_d = LAST_COL;
                        row_d = row_q - ROW_W'(1);
                     end else begin
                        col_d = col_q - COL_W'(1);
                     end
                  end
               end else if (key_ascii == CH_ESC) begin
                  // Address 0 is written on this edge so the clear starts immediately
                  state_d     = ST_CLEAR;
                  we_d        = 1'b1;
                  count_d     = '0;
                  ascdata_d   = CH_SPACE;
                  key_ready_d = 1'b0;
                  clr_d       = ADDR_W'(1);
                  row_d       = '0;
                  col_d       = '0;
                  cur_d       = '0;
               end
            end
         end

         ST_WRITE: begin
            key_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_CLEAR;
            clr_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset into a fresh clear
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         clr_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cur_q       <= '0;
         we_q        <= 1'b0;
         count_q     <= '0;
         ascdata_q   <= 8'h00;
         key_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cur_q       <= cur_d;
         we_q        <= we_d;
         count_q     <= count_d;
         ascdata_q   <= ascdata_d;
         key_ready_q <= key_ready_d;
      end
   end

   assign key_ready = key_ready_q;
   assign we        = we_q;
   assign count     = count_q;
   assign ascdata   = ascdata_q;
   assign cur       = cur_q;

endmodule

// File: tb/tb_text_term_writer.sv
// tb/tb_text_term_writer.sv - randomized self-checking bench for text_term_writer
module tb_text_term_writer;

   localparam int COLS   = 71;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 12;
   localparam int CELLS  = COLS * ROWS;

   logic              clk = 1'b0;
   logic              reset;
   logic              key_valid;
   logic [7:0]        key_ascii;
   logic              key_ready;
   logic              we;
   logic [ADDR_W-1:0] count;
   logic [7:0]        ascdata;
   logic [ADDR_W-1:0] cur;

   int n_cmp = 0;
   int n_bad = 0;

   int          m_cur;
   logic [7:0]  m_screen [CELLS];
   logic [7:0]  ram      [CELLS];

   text_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key_ascii (key_ascii),
      .key_ready (key_ready),
      .we        (we),
      .count     (count),
      .ascdata   (ascdata),
      .cur       (cur)
   );

   always #5 clk = ~clk;

   // Character RAM write port as seen by the renderer side
   always @(posedge clk) begin
      if (we === 1'b1 && int'(count) < CELLS) ram[count] <= ascdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_we", we, 0);
      check("rst_count", count, 0);
      check("rst_ascdata", ascdata, 0);
      check("rst_cur", cur, 0);
      check("rst_key_ready", key_ready, 0);
   endtask

   // Outputs currently show clear cycle k0; follow the clear to its end
   task automatic run_clear(input int k0);
      int bad = 0;
      for (int k = k0; k <= CELLS; k++) begin
         if (k > k0) step();
         if (we !== 1'b1 || int'(count) != k - 1 || ascdata !== 8'h20 ||
             key_ready !== 1'b0 || cur !== '0) bad++;
      end
      check("clear_bad_cycles", bad, 0);
      step();
      check("clear_done_ready", key_ready, 1);
      check("clear_done_we", we, 0);
      check("clear_done_cur", cur, 0);
      m_cur = 0;
      for (int i = 0; i < CELLS; i++) m_screen[i] = 8'h20;
   endtask

   task automatic wait_ready();
      int w = 0;
      while (key_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      if (key_ready !== 1'b1) check("ready_timeout", 0, 1);
   endtask

   task automatic send_key(input logic [7:0] code);
      int row, col, new_cur, addr;
      logic exp_we;
      logic [7:0] data;
      wait_ready();
      key_valid = 1'b1;
      key_ascii = code;
      step();
      key_valid = 1'b0;
      key_ascii = 8'($urandom);
      if (code == 8'h1B) begin
         run_clear(1);
         return;
      end
      row = m_cur / COLS;
      col = m_cur % COLS;
      exp_we = 1'b0;
      addr = 0;
      data = 8'h00;
      new_cur = m_cur;
      if (code >= 8'h20 && code <= 8'h7E) begin
         exp_we = 1'b1; addr = m_cur; data = code;
         new_cur = (m_cur + 1) % CELLS;
      end else if (code == 8'h0D) begin
         new_cur = ((row + 1) % ROWS) * COLS;
      end else if (code == 8'h08 && m_cur > 0) begin
         new_cur = m_cur - 1;
         exp_we = 1'b1; addr = new_cur; data = 8'h20;
      end
      check("key_we", we, exp_we);
      check("key_cur", cur, new_cur);
      check("key_ready_after", key_ready, !exp_we);
      if (exp_we) begin
         check("key_count", count, addr);
         check("key_ascdata", ascdata, data);
         m_screen[addr] = data;
         step();
         check("write_we_drop", we, 0);
         check("write_ready_back", key_ready, 1);
         check("write_count_hold", count, addr);
      end
      m_cur = new_cur;
      if (col < 0) check("col_range", col, 0);
   endtask

   task automatic send_printables(input int n);
      for (int i = 0; i < n; i++) send_key(8'($urandom_range(32, 126)));
   endtask

   initial begin
      int w, bad, r;
      logic [7:0] c;
      reset = 1'b1;
      key_valid = 1'b0;
      key_ascii = 8'h00;
      m_cur = 0;
      repeat (3) step();
      check_reset_vals();

      reset = 1'b0;
      step();
      run_clear(1);

      send_key(8'h41);
      send_key(8'h42);
      check("cur_after_AB", cur, 2);

      send_key(8'h08);
      send_key(8'h08);
      check("cur_home", cur, 0);
      send_printables(COLS);
      check("cur_row1", cur, 71);
      send_key(8'h08);
      check("cur_bs71", cur, 70);

      repeat (ROWS - 1) send_key(8'h0D);
      check("cur_row29", cur, (ROWS - 1) * COLS);
      send_printables(COLS - 1);
      check("cur_last", cur, CELLS - 1);
      send_key(8'h5A);
      check("cur_wrap", cur, 0);
      send_key(8'h08);
      check("cur_bs_home", cur, 0);
      send_key(8'h07);
      check("cur_bell", cur, 0);

      repeat (14) send_key(8'h0D);
      send_printables(6);
      check("cur_1000", cur, 1000);
      send_key(8'h0D);
      check("cur_1065", cur, 1065);

      send_key(8'h1B);
      repeat (7) send_key(8'h0D);
      send_printables(3);
      check("cur_500", cur, 500);
      send_key(8'h1B);

      // ESC again, then reset in the middle of the clear
      wait_ready();
      key_valid = 1'b1;
      key_ascii = 8'h1B;
      step();
      key_valid = 1'b0;
      w = 0;
      while (int'(count) != 1200 && w < 3000) begin
         step();
         w++;
      end
      check("clear_reached_1200", count, 1200);
      reset = 1'b1;
      step();
      check_reset_vals();
      step();
      check_reset_vals();
      reset = 1'b0;
      step();
      run_clear(1);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70) c = 8'($urandom_range(32, 126));
         else if (r < 80) c = 8'h0D;
         else if (r < 92) c = 8'h08;
         else if (r < 99) begin
            c = 8'($urandom_range(0, 31));
            if (c == 8'h08 || c == 8'h0D || c == 8'h1B) c = 8'h7F + 8'($urandom_range(0, 128));
         end else c = 8'h1B;
         send_key(c);
      end
      step();

      bad = 0;
      for (int i = 0; i < CELLS; i++) if (ram[i] !== m_screen[i]) bad++;
      check("screen_cells_bad", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
